// File: rtl/rx_word_align.sv
// rx_word_align
//
// Finds the word boundary of a deserialised lane by searching for a known
// training word. The lane word and the one before it are concatenated and a
// barrel-shift window is slid one bit at a time until the training word lines
// up. The block declares lock after a run of consecutive matches, then freezes
// the offset and passes payload through. It reports an error if alignment
// takes too long.
//
// Ports
//   SCLK            in   1  receive fabric clock
//   RESETN          in   1  asynchronous active-low reset, released synchronously
//   BIT_ALGN_DONE   in   1  bit alignment complete; alignment only runs while high
//   RX_DATA         in   8  deserialised lane word, bit 0 oldest
//   ALGN_RSTRT      in   1  synchronous restart request (held high keeps IDLE)
//   WORD_DATA       out  8  word-aligned data, registered window
//   WORD_VALID      out  1  WORD_DATA is aligned payload (LOCKED)
//   WORD_ALGN_DONE  out  1  lock achieved
//   WORD_ALGN_ERR   out  1  alignment timed out
//   SLIP_OFFSET     out  3  current bit offset of the window
//
// Handshake: there is no flow control. WORD_DATA advances every cycle and
// WORD_VALID qualifies it; the consumer must take every word WORD_VALID marks.

module rx_word_align #(
    parameter logic [7:0]  TRAIN_PATTERN = 8'hE4,
    parameter int unsigned MATCH_COUNT   = 16,
    parameter int unsigned TIMEOUT       = 1023
) (
    input  logic       SCLK,
    input  logic       RESETN,
    input  logic       BIT_ALGN_DONE,
    input  logic [7:0] RX_DATA,
    input  logic       ALGN_RSTRT,
    output logic [7:0] WORD_DATA,
    output logic       WORD_VALID,
    output logic       WORD_ALGN_DONE,
    output logic       WORD_ALGN_ERR,
    output logic [2:0] SLIP_OFFSET
);

    localparam logic [7:0]  MATCH_TGT = 8'(MATCH_COUNT);
    localparam logic [11:0] TMO_TGT   = 12'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEARCH,
        ST_SLIP_WAIT,
        ST_LOCK_CHK,
        ST_LOCKED,
        ST_ERROR
    } state_e;

    state_e      state_q, state_d;
    logic        run_q;
    logic [7:0]  d1_q, d2_q;
    logic [7:0]  word_q;
    logic [2:0]  slip_q, slip_d;
    logic [7:0]  match_q, match_d;
    logic [11:0] tmo_q, tmo_d;
    logic        done_q, done_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    logic [15:0] shifted;
    logic [7:0]  window;
    logic        hit;
    logic [11:0] tmo_inc;
    logic [7:0]  match_inc;
    logic        tmo_hit;

    // d2 is the older word, so offset 0 selects d2 and each slip pulls one
    // newer bit in from d1.
    assign shifted   = {d1_q, d2_q} >> slip_q;
    assign window    = shifted[7:0];
    assign hit       = (window == TRAIN_PATTERN);
    assign tmo_inc   = tmo_q + 12'd1;
    assign match_inc = match_q + 8'd1;
    assign tmo_hit   = (tmo_inc == TMO_TGT);

    always_comb begin
        state_d = state_q;
        slip_d  = slip_q;
        match_d = match_q;
        tmo_d   = tmo_q;

        if (state_q == ST_IDLE) begin
            slip_d  = 3'd0;
            match_d = 8'd0;
            tmo_d   = 12'd0;
            if (BIT_ALGN_DONE && !ALGN_RSTRT) begin
                state_d = ST_SEARCH;
            end
        end else if (ALGN_RSTRT || !BIT_ALGN_DONE) begin
            // Restart or loss of bit alignment abandons everything, including
            // a frozen offset from LOCKED or ERROR.
            state_d = ST_IDLE;
            slip_d  = 3'd0;
            match_d = 8'd0;
            tmo_d   = 12'd0;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    tmo_d = tmo_inc;
                    if (tmo_hit) begin
                        state_d = ST_ERROR;
                    end else if (hit) begin
                        match_d = 8'd1;
                        state_d = (MATCH_TGT == 8'd1) ? ST_LOCKED : ST_LOCK_CHK;
                    end else begin
                        slip_d  = slip_q + 3'd1;
                        state_d = ST_SLIP_WAIT;
                    end
                end
                ST_SLIP_WAIT: begin
                    tmo_d   = tmo_inc;
                    state_d = tmo_hit ? ST_ERROR : ST_SEARCH;
                end
                ST_LOCK_CHK: begin
                    tmo_d = tmo_inc;
                    if (tmo_hit) begin
                        // Timeout wins even if this word would have completed lock.
                        state_d = ST_ERROR;
                    end else if (hit) begin
                        match_d = match_inc;
                        if (match_inc == MATCH_TGT) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        match_d = 8'd0;
                        slip_d  = slip_q + 3'd1;
                        state_d = ST_SLIP_WAIT;
                    end
                end
                ST_LOCKED: begin
                    state_d = ST_LOCKED;
                end
                ST_ERROR: begin
                    state_d = ST_ERROR;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Status flags are registered copies of the next state so they change
        // on the same edge the state does; LOCKED and ERROR are exclusive.
        done_d  = (state_d == ST_LOCKED);
        valid_d = (state_d == ST_LOCKED);
        err_d   = (state_d == ST_ERROR);
    end

    always_ff @(posedge SCLK or negedge RESETN) begin
        if (!RESETN) begin
            run_q   <= 1'b0;
            d1_q    <= 8'h00;
            d2_q    <= 8'h00;
            word_q  <= 8'h00;
            state_q <= ST_IDLE;
            slip_q  <= 3'd0;
            match_q <= 8'd0;
            tmo_q   <= 12'd0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            d1_q   <= RX_DATA;
            d2_q   <= d1_q;
            word_q <= window;
            // run_q delays the control path by one edge after reset release,
            // so the first state update lands on the second edge.
            run_q  <= 1'b1;
            if (run_q) begin
                state_q <= state_d;
                slip_q  <= slip_d;
                match_q <= match_d;
                tmo_q   <= tmo_d;
                done_q  <= done_d;
                valid_q <= valid_d;
                err_q   <= err_d;
            end
        end
    end

    assign WORD_DATA      = word_q;
    assign WORD_VALID     = valid_q;
    assign WORD_ALGN_DONE = done_q;
    assign WORD_ALGN_ERR  = err_q;
    assign SLIP_OFFSET    = slip_q;

endmodule
